// File: rtl/display_scan_ctrl_pkg.sv
// display_pkg: types and constants shared by the display scan controller.
//   scan_state_t  : scan FSM state encoding (BLANK, SCAN, GUARD)
//   SEG_0..SEG_9  : active-low segment patterns, bit order {g,f,e,d,c,b,a}
//   SEG_OFF       : all segments dark
package display_pkg;

  typedef enum logic [1:0] {
    BLANK = 2'd0,
    SCAN  = 2'd1,
    GUARD = 2'd2
  } scan_state_t;

  localparam logic [6:0] SEG_0   = 7'b1000000;
  localparam logic [6:0] SEG_1   = 7'b1111001;
  localparam logic [6:0] SEG_2   = 7'b0100100;
  localparam logic [6:0] SEG_3   = 7'b0110000;
  localparam logic [6:0] SEG_4   = 7'b0011001;
  localparam logic [6:0] SEG_5   = 7'b0010010;
  localparam logic [6:0] SEG_6   = 7'b0000010;
  localparam logic [6:0] SEG_7   = 7'b1111000;
  localparam logic [6:0] SEG_8   = 7'b0000000;
  localparam logic [6:0] SEG_9   = 7'b0011000;
  localparam logic [6:0] SEG_OFF = 7'b1111111;

endpackage

// File: rtl/display_scan_ctrl_if.sv
// display_scan_ctrl_if: frame load handshake into the scan controller.
//   ld_valid : producer offers a new frame
//   ld_data  : 4*DIGITS bits of BCD, digit 0 in [3:0]
//   ld_ready : controller's shadow register is free
// master = frame producer, slave = display_scan_ctrl.
interface display_scan_ctrl_if #(
  parameter int DIGITS = 4
) ();

  logic                ld_valid;
  logic [4*DIGITS-1:0] ld_data;
  logic                ld_ready;

  modport master (output ld_valid, output ld_data, input ld_ready);
  modport slave  (input ld_valid, input ld_data, output ld_ready);

endinterface

// File: rtl/display_scan_ctrl_seg_decoder.sv
// seg_decoder: combinational BCD to 7-segment decode.
//   bcd : 4-bit BCD digit; codes 10..15 display as 0
//   seg : active-low segments {g,f,e,d,c,b,a}
module seg_decoder
  import display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_0;
    endcase
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: multiplexed 7-segment scan controller with a
// double-buffered frame load.
//   clk, rst_n   : clock, async active-low reset
//   en           : display enable, 0 blanks and parks the scan at digit 0
//   ld           : frame load handshake (display_scan_ctrl_if.slave)
//   seg          : active-low segments {g,f,e,d,c,b,a}
//   an           : active-low one-hot digit select
//   frame_done   : one-cycle pulse after the last digit's slot
// Build option: define LEADING_ZERO_BLANK_EN to darken digits above the
// most-significant nonzero digit (digit 0 is always shown).
//
// state | meaning
// BLANK | display off, divider and digit index held at 0
// SCAN  | digit idx lit for REFRESH_DIV cycles
// GUARD | one dark cycle between digits to avoid ghosting
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  display_scan_ctrl_if.slave  ld,
  output logic [6:0]          seg,
  output logic [DIGITS-1:0]   an,
  output logic                frame_done
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(REFRESH_DIV - 1);

  scan_state_t         state_q, state_d;
  logic [DW-1:0]       div_q, div_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0] display_q, shadow_q;
  logic                full_q;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [6:0]          seg_q, seg_d, dec_seg;
  logic                frame_done_q;
  logic [3:0]          nib;
  logic                lz_blank;
  logic                div_wrap, frame_wrap, accept, xfer;

  assign div_wrap   = (state_q == SCAN) && (div_q == DIV_LAST);
  assign frame_wrap = en && div_wrap && (idx_q == IDX_LAST);
  assign accept     = ld.ld_valid && !full_q;
  // While blanked nothing is being shown, so hand the frame over at once.
  assign xfer       = full_q && (frame_wrap || !en);
  assign ld.ld_ready = !full_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BLANK;
      div_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    idx_d   = idx_q;
    if (!en) begin
      state_d = BLANK;
      div_d   = '0;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        BLANK: begin
          state_d = SCAN;
          div_d   = '0;
          idx_d   = '0;
        end
        SCAN: begin
          if (div_wrap) begin
            state_d = GUARD;
            div_d   = '0;
            idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
          end else begin
            div_d = div_q + DW'(1);
          end
        end
        GUARD:   state_d = SCAN;
        default: state_d = BLANK;
      endcase
    end
  end

  // Outputs are registered from the next state so an/seg line up with state_q.
  always_comb begin
    nib = 4'd0;
    for (int i = 0; i < DIGITS; i++)
      if (idx_d == IW'(i)) nib = display_q[4*i +: 4];
  end

  seg_decoder u_dec (
    .bcd (nib),
    .seg (dec_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  logic [IW-1:0] msd;
  always_comb begin
    msd = '0;
    for (int i = 1; i < DIGITS; i++)
      if (display_q[4*i +: 4] != 4'd0) msd = IW'(i);
  end
  assign lz_blank = (idx_d > msd);
`else
  assign lz_blank = 1'b0;
`endif

  always_comb begin
    an_d  = '1;
    seg_d = SEG_OFF;
    if (state_d == SCAN) begin
      an_d[idx_d] = 1'b0;
      seg_d       = lz_blank ? SEG_OFF : dec_seg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q         <= '1;
      seg_q        <= SEG_OFF;
      frame_done_q <= 1'b0;
    end else begin
      an_q         <= an_d;
      seg_q        <= seg_d;
      frame_done_q <= frame_wrap;
    end
  end

  // accept and xfer are mutually exclusive: accept needs an empty shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q  <= '0;
      display_q <= '0;
      full_q    <= 1'b0;
    end else if (accept) begin
      shadow_q <= ld.ld_data;
      full_q   <= 1'b1;
    end else if (xfer) begin
      display_q <= shadow_q;
      full_q    <= 1'b0;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: directed self-checking bench for display_scan_ctrl
// (DIGITS=4, REFRESH_DIV=4). Honours LEADING_ZERO_BLANK_EN in its
// expected segment values.
module tb_display_scan_ctrl;

  localparam int DIGITS = 4;
  localparam int RDIV   = 4;
  localparam logic [6:0] OFF = 7'b1111111;
  localparam logic [6:0] S0  = 7'b1000000;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en;
  logic [6:0]        seg;
  logic [DIGITS-1:0] an;
  logic              frame_done;
  int                n_tests = 0;
  int                n_fail  = 0;

  display_scan_ctrl_if #(.DIGITS(DIGITS)) ld_if ();

  display_scan_ctrl #(.DIGITS(DIGITS), .REFRESH_DIV(RDIV)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .ld         (ld_if),
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] dec(input logic [3:0] b);
    case (b)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0011000;
      default: return 7'b1000000;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input logic [15:0] d, input int k);
    logic [3:0] n;
    logic       nz;
    n  = d[4*k +: 4];
    nz = 1'b0;
    for (int j = k; j < DIGITS; j++)
      if (d[4*j +: 4] != 4'd0) nz = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
    if (k > 0 && !nz) return OFF;
`endif
    return dec(n);
  endfunction

  // Starts on the first lit cycle of digit 0, ends on the next frame's.
  task automatic scan_frame(input logic [15:0] d);
    logic [3:0] an_exp;
    logic [6:0] seg_exp;
    for (int k = 0; k < DIGITS; k++) begin
      an_exp  = ~(4'b0001 << k);
      seg_exp = exp_seg(d, k);
      for (int c = 0; c < RDIV; c++) begin
        check($sformatf("an %h d%0d c%0d", d, k, c), 32'(an), 32'(an_exp));
        check($sformatf("seg %h d%0d c%0d", d, k, c), 32'(seg), 32'(seg_exp));
        tick();
      end
      check($sformatf("guard an %h d%0d", d, k), 32'(an), 32'hF);
      check($sformatf("guard seg %h d%0d", d, k), 32'(seg), 32'(OFF));
      check($sformatf("frame_done %h d%0d", d, k), 32'(frame_done), 32'(k == DIGITS - 1));
      tick();
    end
  endtask

  task automatic load_blanked(input logic [15:0] d);
    ld_if.ld_valid = 1'b1;
    ld_if.ld_data  = d;
    tick();
    check("ready drop", 32'(ld_if.ld_ready), 32'd0);
    ld_if.ld_valid = 1'b0;
    tick();
    check("ready rise blanked", 32'(ld_if.ld_ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   waited;
    logic early;
    rst_n          = 1'b0;
    en             = 1'b0;
    ld_if.ld_valid = 1'b0;
    ld_if.ld_data  = '0;
    #12;
    check("rst an", 32'(an), 32'hF);
    check("rst seg", 32'(seg), 32'(OFF));
    check("rst ready", 32'(ld_if.ld_ready), 32'd1);
    check("rst frame_done", 32'(frame_done), 32'd0);
    rst_n = 1'b1;
    tick();
    check("blank an", 32'(an), 32'hF);

    // 1234 loaded while blanked, then scanned
    load_blanked(16'h1234);
    en = 1'b1;
    tick();
    scan_frame(16'h1234);

    // back-to-back offers: second held until the frame boundary
    ld_if.ld_valid = 1'b1;
    ld_if.ld_data  = 16'h1111;
    tick();
    check("b2b ready low", 32'(ld_if.ld_ready), 32'd0);
    ld_if.ld_data = 16'h2222;
    waited = 0;
    early  = 1'b0;
    while (frame_done !== 1'b1 && waited < 40) begin
      if (ld_if.ld_ready) early = 1'b1;
      tick();
      waited++;
    end
    check("b2b frame_done wait", 32'(waited), 32'd18);
    check("b2b held off", 32'(early), 32'd0);
    check("b2b ready after xfer", 32'(ld_if.ld_ready), 32'd1);
    tick();
    ld_if.ld_valid = 1'b0;
    check("b2b second taken", 32'(ld_if.ld_ready), 32'd0);
    scan_frame(16'h1111);
    scan_frame(16'h2222);
    check("b2b ready idle", 32'(ld_if.ld_ready), 32'd1);

    // codes above 9 and blanked-mode transfer
    en = 1'b0;
    tick();
    check("en off an", 32'(an), 32'hF);
    check("en off seg", 32'(seg), 32'(OFF));
    load_blanked(16'h00AF);
    en = 1'b1;
    tick();
    scan_frame(16'h00AF);

    // en dropped during digit 2
    repeat (11) tick();
    check("mid d2 an", 32'(an), 32'hB);
    en = 1'b0;
    tick();
    check("drop an", 32'(an), 32'hF);
    check("drop seg", 32'(seg), 32'(OFF));
    tick();
    tick();
    check("drop hold an", 32'(an), 32'hF);
    check("drop frame_done", 32'(frame_done), 32'd0);
    en = 1'b1;
    tick();
    check("restart an", 32'(an), 32'hE);
    check("restart seg", 32'(seg), 32'(S0));
    repeat (RDIV) tick();

    // leading zeros
    en = 1'b0;
    tick();
    load_blanked(16'h0042);
    en = 1'b1;
    tick();
    scan_frame(16'h0042);

    // reset mid-frame with a pending shadow frame
    ld_if.ld_valid = 1'b1;
    ld_if.ld_data  = 16'h5678;
    tick();
    check("pend ready", 32'(ld_if.ld_ready), 32'd0);
    ld_if.ld_valid = 1'b0;
    tick();
    #1;
    rst_n = 1'b0;
    #1;
    check("async rst an", 32'(an), 32'hF);
    check("async rst seg", 32'(seg), 32'(OFF));
    check("async rst ready", 32'(ld_if.ld_ready), 32'd1);
    check("async rst frame_done", 32'(frame_done), 32'd0);
    #2;
    rst_n = 1'b1;
    tick();
    check("post rst an", 32'(an), 32'hE);
    scan_frame(16'h0000);
    check("shadow discarded seg", 32'(seg), 32'(S0));
    check("shadow discarded ready", 32'(ld_if.ld_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 Parameter DIGITS, default 4, number of multiplexed digits (2..8).
REQ-002 Parameter REFRESH_DIV, default 50000, clk cycles each digit is lit (>=2).
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 en  input  1  display enable; 0 blanks all digits.
REQ-006 ld_valid  input  1  new frame offered.
REQ-007 ld_data  input  4*DIGITS  BCD nibbles, digit 0 in bits [3:0].
REQ-008 ld_ready  output  1  shadow register free, frame accepted when ld_valid&&ld_ready.
REQ-009 seg  output  7  active-low segments {g,f,e,d,c,b,a}.
REQ-010 an  output  DIGITS  active-low digit selects, one-hot-low.
REQ-011 frame_done  output  1  one-cycle pulse after last digit's slot ends.

Function
REQ-012 Handshake: on ld_valid&&ld_ready, ld_data SHALL be captured into a shadow register and ld_ready SHALL drop the next cycle.
REQ-013 Shadow SHALL transfer to the display register only at frame boundary (digit DIGITS-1 slot ending); ld_ready SHALL rise the cycle after transfer.
REQ-014 If ld_valid is offered in the same cycle as the boundary transfer while ld_ready=0, the offer SHALL not be accepted; no frame is dropped or overwritten.
REQ-015 Divider counts 0..REFRESH_DIV-1; at REFRESH_DIV-1 it wraps to 0 and the digit index advances.
REQ-016 Digit index counts 0..DIGITS-1 and wraps to 0; frame_done pulses on the wrap cycle.
REQ-017 FSM states: BLANK (en=0: an all 1, seg all 1, counters held at 0), SCAN (digit lit), GUARD (one cycle, an all 1, on every digit change to prevent ghosting).
REQ-018 Transitions: BLANK->SCAN when en=1; SCAN->GUARD at divider wrap; GUARD->SCAN next cycle; any state->BLANK when en=0 (counters reset to 0, shadow/handshake unaffected).
REQ-019 In SCAN, an SHALL drive bit[index]=0 only; seg SHALL equal decode(display nibble[index]) registered, one-cycle latency from index change.
REQ-020 Decode: 0..9 standard active-low patterns (0=1000000, 1=1111001, 8=0000000, 9=0011000); codes 10..15 SHALL display the 0 pattern.
REQ-021 Boundary transfers while en=0 SHALL occur immediately (shadow->display next cycle) so a blanked display always resumes with latest data.

Reset
REQ-022 Asynchronous assertion of rst_n=0 SHALL force: state BLANK, index 0, divider 0, display and shadow 0, ld_ready 1, an all 1, seg 1111111, frame_done 0.
REQ-023 Deassertion SHALL be released synchronously-safe; first state update on the first rising clk after rst_n=1; reset mid-frame discards any pending shadow frame.

Configuration
REQ-024 Macro LEADING_ZERO_BLANK_EN: when defined, digits above the most-significant nonzero digit SHALL show seg=1111111 (an still cycles); digit 0 always shown; when undefined all digits are decoded normally.

Structure
REQ-025 Shared package display_pkg SHALL hold the state enum (BLANK, SCAN, GUARD), segment pattern constants SEG_0..SEG_9 and SEG_OFF.
REQ-026 One sub-module seg_decoder (4-bit BCD in, 7-bit active-low out, combinational) SHALL be instantiated once and shared across all digits.

Verification
REQ-027 Reset then en=1, ld_data=16'h1234 load -> within one frame an cycles 1110,1101,1011,0111 with seg 0011001,0110000,0100100,1111001.
REQ-028 Two back-to-back ld_valid frames 16'h1111 then 16'h2222 -> second held off (ld_ready=0) until frame_done; display never shows mixed digits.
REQ-029 ld_data=16'h00AF with REFRESH_DIV=4 -> A,F digits show 1000000; each digit lit exactly 4 cycles plus 1 GUARD cycle with an=1111.
REQ-030 en dropped mid-digit 2 -> next cycle an=1111, seg=1111111; en restored -> scan restarts at digit 0.
REQ-031 rst_n pulsed low mid-frame with shadow pending -> outputs at reset values asynchronously; ld_ready=1; display=0 after release.
REQ-032 With LEADING_ZERO_BLANK_EN, ld_data=16'h0042 -> digits 3,2 seg=1111111, digits 1,0 show 4,2; ld_data=0 -> only digit 0 shows 1000000.
